// File: rtl/nn_input_feeder_if.sv
// Handshake bundle between the host, the input feeder and the accelerator input port.
// slave = feeder side, master = host/accelerator side.
interface nn_input_feeder_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  feed_valid;
  logic [DATA_WIDTH-1:0] feed_data;
  logic                  feed_last;
  logic                  acc_ready;

  modport slave (
    input  in_valid, in_data, acc_ready,
    output in_ready, feed_valid, feed_data, feed_last
  );

  modport master (
    output in_valid, in_data, acc_ready,
    input  in_ready, feed_valid, feed_data, feed_last
  );
endinterface

// File: rtl/nn_input_feeder.sv
// FIFO feeder between host and accelerator with vector element tracking.
// Optional FEEDER_OVF_EN adds a sticky overflow flag for pushes attempted while full.
module nn_input_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int VEC_LEN    = 3,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1,
  localparam int EW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1
) (
  input  logic            clk,
  input  logic            reset,
  nn_input_feeder_if.slave bus,
  input  logic            flush,
  output logic [CW-1:0]   count,
  output logic [EW-1:0]   elem_idx
`ifdef FEEDER_OVF_EN
  ,
  output logic            overflow
`endif
);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [EW-1:0]         elem_idx_reg;
  logic                  push;
  logic                  pop;
  logic                  elem_wrap;

  // Handshake status decodes the registered count only, so a same-cycle pop never frees a full slot early.
  assign bus.in_ready   = (count_reg != CW'(DEPTH));
  assign bus.feed_valid = (count_reg != '0);
  assign bus.feed_data  = mem_reg[rd_ptr_reg];
  assign elem_wrap      = (elem_idx_reg == EW'(VEC_LEN - 1));
  assign bus.feed_last  = bus.feed_valid && elem_wrap;

  assign push = bus.in_valid && bus.in_ready && !flush;
  assign pop  = bus.feed_valid && bus.acc_ready && !flush;

  assign count    = count_reg;
  assign elem_idx = elem_idx_reg;

  // Storage has no reset; stale entries are never visible because feed_valid gates them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      elem_idx_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      elem_idx_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        elem_idx_reg <= elem_wrap ? '0 : elem_idx_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef FEEDER_OVF_EN
  logic overflow_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
    end else if (flush) begin
      overflow_reg <= 1'b0;
    end else if (bus.in_valid && !bus.in_ready) begin
      overflow_reg <= 1'b1;
    end
  end

  assign overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_nn_input_feeder.sv
// Scoreboard bench for nn_input_feeder: stimulus queues expected words, a negedge monitor
// checks every accepted pop (order, feed_last, elem_idx) independently of the stimulus.
module tb_nn_input_feeder;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [2:0] count;
  logic [1:0] elem_idx;
`ifdef FEEDER_OVF_EN
  logic       overflow;
`endif

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_q [$];
  int         exp_elem = 0;

  nn_input_feeder_if #(.DATA_WIDTH(8)) bus ();

  nn_input_feeder #(
    .DATA_WIDTH(8),
    .DEPTH(4),
    .VEC_LEN(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .flush    (flush),
    .count    (count),
    .elem_idx (elem_idx)
`ifdef FEEDER_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic ar);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.acc_ready = ar;
  endtask

  // Monitor: a pop happens at the next edge when valid && ready and no flush/reset.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && !flush && bus.feed_valid && bus.acc_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_pop: got %0h expected none", bus.feed_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("pop_data", {24'd0, bus.feed_data}, {24'd0, e});
          chk("pop_last", {31'd0, bus.feed_last}, {31'd0, (exp_elem == 2)});
          chk("pop_elem", {30'd0, elem_idx}, exp_elem);
          $display("pop data=%0h last=%0b elem=%0d", bus.feed_data, bus.feed_last, elem_idx);
          exp_elem = (exp_elem == 2) ? 0 : exp_elem + 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Head-of-FIFO checks for the vector framing stream 0x10..0x15.
  logic [0:5] last_tbl;
  int         idx_tbl [6];

  initial begin
    last_tbl = 6'b001001;
    idx_tbl  = '{0, 1, 2, 0, 1, 2};
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);

    // Reset / idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
    chk("rst_feed_valid", {31'd0, bus.feed_valid}, 0);
    chk("rst_feed_last", {31'd0, bus.feed_last}, 0);
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_elem", {30'd0, elem_idx}, 0);
`ifdef FEEDER_OVF_EN
    chk("rst_overflow", {31'd0, overflow}, 0);
`endif
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("idle_elem", {30'd0, elem_idx}, 0);
    end
    $display("reset/idle done");

    // Single word, consumer stalled then released
    drive(1'b1, 8'h5A, 1'b0);
    exp_q.push_back(8'h5A);
    cyc();
    drive(1'b0, 8'h00, 1'b0);
    chk("single_valid", {31'd0, bus.feed_valid}, 1);
    chk("single_data", {24'd0, bus.feed_data}, 32'h5A);
    chk("single_count", {29'd0, count}, 1);
    chk("single_last", {31'd0, bus.feed_last}, 0);
    cyc();
    chk("stall_data", {24'd0, bus.feed_data}, 32'h5A);
    chk("stall_elem", {30'd0, elem_idx}, 0);
    bus.acc_ready = 1'b1;
    cyc();
    bus.acc_ready = 1'b0;
    chk("single_pop_count", {29'd0, count}, 0);
    chk("single_pop_elem", {30'd0, elem_idx}, 1);
    $display("single word done");

    // Fill to full; 5th word refused
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      chk("fill_in_ready", {31'd0, bus.in_ready}, (i <= 4) ? 1 : 0);
      if (i <= 4) exp_q.push_back(8'(i));
      cyc();
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("full_count", {29'd0, count}, 4);
    chk("full_in_ready", {31'd0, bus.in_ready}, 0);
`ifdef FEEDER_OVF_EN
    chk("full_overflow", {31'd0, overflow}, 1);
`endif
    // Pop while full: in_ready stays low this cycle, held word lands next cycle
    drive(1'b1, 8'h06, 1'b1);
    chk("full_pop_in_ready", {31'd0, bus.in_ready}, 0);
    cyc();
    drive(1'b1, 8'h06, 1'b0);
    chk("after_pop_in_ready", {31'd0, bus.in_ready}, 1);
    chk("after_pop_count", {29'd0, count}, 3);
    exp_q.push_back(8'h06);
    cyc();
    drive(1'b0, 8'h00, 1'b0);
    chk("refill_count", {29'd0, count}, 4);
    $display("fill/full done");

    // Drain two: 0x02 is element 2 of its vector
    chk("drain_last", {31'd0, bus.feed_last}, 1);
    bus.acc_ready = 1'b1;
    cyc();
    cyc();
    bus.acc_ready = 1'b0;
    chk("drain_count", {29'd0, count}, 2);
    chk("drain_elem", {30'd0, elem_idx}, 1);

    // Simultaneous push and pop at count 2
    drive(1'b1, 8'h77, 1'b1);
    exp_q.push_back(8'h77);
    cyc();
    drive(1'b0, 8'h00, 1'b1);
    chk("simul_count", {29'd0, count}, 2);
    chk("simul_head", {24'd0, bus.feed_data}, 32'h06);
    cyc();
    chk("simul_head2", {24'd0, bus.feed_data}, 32'h77);
    cyc();
    bus.acc_ready = 1'b0;
    chk("simul_empty", {29'd0, count}, 0);
    $display("simultaneous push/pop done");

    // Flush with count 3, elem_idx 1, and a same-cycle push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h81 + i), 1'b0);
      exp_q.push_back(8'(8'h81 + i));
      cyc();
    end
    chk("preflush_count", {29'd0, count}, 3);
    chk("preflush_elem", {30'd0, elem_idx}, 1);
    drive(1'b1, 8'h99, 1'b1);
    flush = 1'b1;
    chk("flush_in_ready", {31'd0, bus.in_ready}, 1);
    chk("flush_feed_valid", {31'd0, bus.feed_valid}, 1);
    cyc();
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    exp_q.delete();
    exp_elem = 0;
    chk("flush_count", {29'd0, count}, 0);
    chk("flush_elem", {30'd0, elem_idx}, 0);
    chk("flush_feed_valid_after", {31'd0, bus.feed_valid}, 0);
`ifdef FEEDER_OVF_EN
    chk("flush_overflow", {31'd0, overflow}, 0);
`endif
    cyc();
    chk("flush_discard", {31'd0, bus.feed_valid}, 0);
    $display("flush done");

    // Vector framing stream, both sides ready
    for (int i = 0; i <= 6; i++) begin
      drive(i < 6, 8'(8'h10 + i), 1'b1);
      if (i >= 1) begin
        chk("frame_data", {24'd0, bus.feed_data}, 32'(8'h10 + i - 1));
        chk("frame_last", {31'd0, bus.feed_last}, {31'd0, last_tbl[i-1]});
        chk("frame_elem", {30'd0, elem_idx}, idx_tbl[i-1]);
        chk("frame_count", {29'd0, count}, 1);
      end
      if (i < 6) exp_q.push_back(8'(8'h10 + i));
      cyc();
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("frame_end_count", {29'd0, count}, 0);
    $display("vector framing done");

    // Asynchronous reset between edges
    drive(1'b1, 8'hA1, 1'b0);
    exp_q.push_back(8'hA1);
    cyc();
    drive(1'b1, 8'hA2, 1'b1);
    exp_q.push_back(8'hA2);
    cyc();
    drive(1'b0, 8'h00, 1'b0);
    chk("prerst_elem", {30'd0, elem_idx}, 1);
    #2;
    reset = 1'b0;
    exp_q.delete();
    exp_elem = 0;
    #1;
    chk("arst_feed_valid", {31'd0, bus.feed_valid}, 0);
    chk("arst_in_ready", {31'd0, bus.in_ready}, 1);
    chk("arst_count", {29'd0, count}, 0);
    chk("arst_elem", {30'd0, elem_idx}, 0);
    cyc();
    reset = 1'b1;
    drive(1'b1, 8'hB2, 1'b0);
    exp_q.push_back(8'hB2);
    cyc();
    drive(1'b0, 8'h00, 1'b1);
    chk("postrst_data", {24'd0, bus.feed_data}, 32'hB2);
    chk("postrst_elem", {30'd0, elem_idx}, 0);
    cyc();
    bus.acc_ready = 1'b0;
    chk("postrst_count", {29'd0, count}, 0);
    $display("async reset done");

    repeat (3) cyc();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
